priority_arbiter: RTL

- Parametrised, registered successor to the 4-input combinational priority encoder.
- Arbitrates N request lines and emits a one-hot grant, an encoded grant index and a valid flag.
- A grant is held (locked) until its requester releases.
- Selectable fixed-priority or round-robin mode.
- Used wherever several lab blocks share one resource, e.g. a display or bus driver.

---
 rtl/priority_arbiter.sv | 86 ++++++++
 1 files changed

// File: rtl/priority_arbiter.sv
// rtl/priority_arbiter.sv - registered N-way priority / round-robin arbiter with grant locking
module priority_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             rr_mode,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] fixed_idx, rr_idx, win_idx, pos;
  logic [N-1:0]     win_onehot;
  logic             rr_found, decide;
  int               rr_start, pos_int;

  // Fixed priority: the loop leaves the highest asserted index behind.
  always_comb begin
    fixed_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) fixed_idx = IDX_W'(i);
    end
  end

  // Round-robin: walk downward from one below the last winner, wrapping past 0.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    pos_int  = 0;
    pos      = '0;
    rr_start = (last_idx == '0) ? N - 1 : int'(last_idx) - 1;
    for (int k = 0; k < N; k++) begin
      pos_int = rr_start - k;
      if (pos_int < 0) pos_int = pos_int + N;
      pos = IDX_W'(pos_int);
      if (!rr_found && req[pos]) begin
        rr_idx   = pos;
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    win_idx             = rr_mode ? rr_idx : fixed_idx;
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
    // A new winner is taken from idle, or when the holder lets go while others wait.
    decide              = (|req) && ((state == IDLE) || !req[grant_idx]);
    next_state          = state;
    case (state)
      IDLE:    if (|req) next_state = GRANT;
      GRANT:   if (!(|req)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      valid     <= 1'b0;
      last_idx  <= '0;
    end else begin
      state <= next_state;
      if (decide) begin
        grant     <= win_onehot;
        grant_idx <= win_idx;
        valid     <= 1'b1;
        last_idx  <= win_idx;
      end else if (next_state == IDLE) begin
        grant     <= '0;
        grant_idx <= '0;
        valid     <= 1'b0;
      end
    end
  end

endmodule
